// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key synchronise/debounce and the IDLE/RUN/PAUSE/FULL state machine.
// Define STOPWATCH_LAP_EN to add the lap key and the lap_freeze output.
module stopwatch_key #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    logic       sync_p0;
    logic       sync_p1;
    logic       level;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            cnt     <= 8'd0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= 8'd0;
            end else if (cnt == 8'(DEBOUNCE_MS)) begin
                // Accepting a change away from released (1) is a press.
                level <= sync_p1;
                cnt   <= 8'd0;
                press <= level;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       key_reset_n,
`ifdef STOPWATCH_LAP_EN
    input  logic       key_lap_n,
`endif
    input  logic       at_max,
    output logic       enable,
    output logic       reset_counter,
`ifdef STOPWATCH_LAP_EN
    output logic       lap_freeze,
`endif
    output logic [1:0] state,
    output logic       run_led
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t st;
    logic   start_evt;
    logic   reset_evt;

    stopwatch_key #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_start (
        .clk(clk), .rst_n(rst_n), .key_n(key_start_n), .press(start_evt)
    );
    stopwatch_key #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_reset (
        .clk(clk), .rst_n(rst_n), .key_n(key_reset_n), .press(reset_evt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= IDLE;
            enable        <= 1'b0;
            reset_counter <= 1'b0;
        end else begin
            reset_counter <= 1'b0;
            // Reset outranks every other event in every state.
            if (reset_evt) begin
                st            <= IDLE;
                enable        <= 1'b0;
                reset_counter <= 1'b1;
            end else begin
                case (st)
                    IDLE: if (start_evt) begin
                        st     <= RUN;
                        enable <= 1'b1;
                    end
                    RUN: if (at_max) begin
                        st     <= FULL;
                        enable <= 1'b0;
                    end else if (start_evt) begin
                        st     <= PAUSE;
                        enable <= 1'b0;
                    end
                    PAUSE: if (start_evt) begin
                        st     <= RUN;
                        enable <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_evt;

    stopwatch_key #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_lap (
        .clk(clk), .rst_n(rst_n), .key_n(key_lap_n), .press(lap_evt)
    );

    // Freeze only survives while the watch stays in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_freeze <= 1'b0;
        end else if (st != RUN || reset_evt || at_max || start_evt) begin
            lap_freeze <= 1'b0;
        end else if (lap_evt) begin
            lap_freeze <= ~lap_freeze;
        end
    end
`endif

    assign state   = st;
    assign run_led = enable;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a window-based debounce model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;
    localparam int N = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_start_n = 1'b1;
    logic       key_reset_n = 1'b1;
    logic       key_lap_n = 1'b1;
    logic       at_max = 1'b0;
    logic       enable;
    logic       reset_counter;
    logic       lap_freeze;
    logic [1:0] state;
    logic       run_led;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.DEBOUNCE_MS(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_start_n(key_start_n),
        .key_reset_n(key_reset_n),
`ifdef STOPWATCH_LAP_EN
        .key_lap_n(key_lap_n),
`endif
        .at_max(at_max),
        .enable(enable),
        .reset_counter(reset_counter),
`ifdef STOPWATCH_LAP_EN
        .lap_freeze(lap_freeze),
`endif
        .state(state),
        .run_led(run_led)
    );
`ifndef STOPWATCH_LAP_EN
    assign lap_freeze = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       rc;
        logic       lap;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int m_state;
    bit m_rc, m_lap;
    bit ev_s, ev_r, ev_l;
    bit deb_s, deb_r, deb_l;
    bit hs[$], hr[$], hl[$];

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    // True when the N+1 synchronised samples ending two edges ago all equal v.
    function automatic bit win_all(input bit h[$], input bit v);
        for (int i = 0; i <= N; i++)
            if (h[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_rc = 0; m_lap = 0;
        ev_s = 0; ev_r = 0; ev_l = 0;
        deb_s = 1; deb_r = 1; deb_l = 1;
        hs.delete(); hr.delete(); hl.delete();
        for (int i = 0; i < N + 3; i++) begin
            hs.push_back(1'b1); hr.push_back(1'b1); hl.push_back(1'b1);
        end
    endtask

    task automatic model_edge();
        bit s, r, l;
        exp_t e;
        s = ev_s; r = ev_r; l = ev_l;
        m_rc = 0;
        if (r) begin
            m_state = 0; m_rc = 1; m_lap = 0;
        end else begin
            case (m_state)
                0: if (s) m_state = 1;
                1: begin
                    if (at_max) begin m_state = 3; m_lap = 0; end
                    else if (s) begin m_state = 2; m_lap = 0; end
                    else if (l) m_lap = !m_lap;
                end
                2: if (s) m_state = 1;
                default: ;
            endcase
        end
        hs.push_back(key_start_n); void'(hs.pop_front());
        hr.push_back(key_reset_n); void'(hr.pop_front());
        hl.push_back(key_lap_n);   void'(hl.pop_front());
        ev_s = deb_s && win_all(hs, 1'b0);
        ev_r = deb_r && win_all(hr, 1'b0);
        ev_l = deb_l && win_all(hl, 1'b0);
        if (win_all(hs, !deb_s)) deb_s = !deb_s;
        if (win_all(hr, !deb_r)) deb_r = !deb_r;
        if (win_all(hl, !deb_l)) deb_l = !deb_l;
        e.st = 2'(m_state); e.en = (m_state == 1); e.rc = m_rc; e.lap = m_lap;
        sb.push_back(e);
    endtask

    // Called at a negedge; advances one clock and returns at the next negedge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n) begin
            model_edge();
        end else begin
            model_reset();
            e = '0;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic set_key(input int which, input bit v);
        case (which)
            0: key_start_n = v;
            1: key_reset_n = v;
            default: key_lap_n = v;
        endcase
    endtask

    task automatic press_key(input int which, input int hold);
        set_key(which, 1'b0);
        repeat (hold) tick();
        set_key(which, 1'b1);
        repeat (N + 10) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state", int'(state), int'(e.st));
            check("enable", int'(enable), int'(e.en));
            check("run_led", int'(run_led), int'(e.en));
            check("reset_counter", int'(reset_counter), int'(e.rc));
`ifdef STOPWATCH_LAP_EN
            check("lap_freeze", int'(lap_freeze), int'(e.lap));
`endif
        end
    end

    initial begin
        model_reset();
        @(negedge clk);
        repeat (3) tick();
        check("reset_state", int'(state), 0);
        check("reset_enable", int'(enable), 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Bouncing start key must never be accepted
        for (int i = 0; i < 12; i++) begin
            key_start_n = ~key_start_n;
            repeat (5) tick();
        end
        key_start_n = 1'b1;
        repeat (30) tick();
        check("bounce_idle", int'(state), 0);

        // Clean press: enable must rise exactly after edge N+3
        key_start_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("latency_enable", int'(enable), ((k - 1) >= N + 3) ? 1 : 0);
        end
        key_start_n = 1'b1;
        repeat (30) tick();
        check("run_after_release", int'(state), 1);

        // RUN -> PAUSE -> RUN -> IDLE
        press_key(0, 30);
        check("pause", int'(state), 2);
        press_key(0, 30);
        check("resume", int'(state), 1);
        press_key(1, 30);
        check("reset_idle", int'(state), 0);

        // Saturation into FULL; start ignored there
        press_key(0, 25);
        at_max = 1'b1;
        repeat (3) tick();
        check("full", int'(state), 3);
        press_key(0, 25);
        check("full_ignores_start", int'(state), 3);
        press_key(1, 25);
        at_max = 1'b0;
        check("full_reset", int'(state), 0);

        // Simultaneous start+reset in PAUSE, with at_max high in PAUSE
        press_key(0, 25);
        press_key(0, 25);
        at_max = 1'b1;
        repeat (5) tick();
        check("pause_ignores_max", int'(state), 2);
        at_max = 1'b0;
        key_start_n = 1'b0;
        key_reset_n = 1'b0;
        repeat (30) tick();
        key_start_n = 1'b1;
        key_reset_n = 1'b1;
        repeat (30) tick();
        check("both_keys_idle", int'(state), 0);

`ifdef STOPWATCH_LAP_EN
        press_key(0, 25);
        press_key(2, 25);
        check("lap_set", int'(lap_freeze), 1);
        press_key(0, 25);
        check("lap_clear_on_pause", int'(lap_freeze), 0);
        press_key(1, 25);
`endif

        // Async reset mid-RUN with start held through release
        press_key(0, 25);
        key_start_n = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_enable", int'(enable), 0);
        check("async_rc", int'(reset_counter), 0);
        model_reset();
        @(negedge clk);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        key_start_n = 1'b1;
        repeat (40) tick();
        check("no_evt_after_reset", int'(state), 0);

        // Randomised key activity and saturation
        for (int i = 0; i < 40; i++) begin
            int which;
            which = $urandom_range(0, 9);
            at_max = ($urandom_range(0, 5) == 0);
            if (which < 5) begin
                set_key(0, 1'b0);
                repeat ($urandom_range(1, 40)) tick();
                set_key(0, 1'b1);
            end else if (which < 7) begin
                set_key(1, 1'b0);
                repeat ($urandom_range(1, 40)) tick();
                set_key(1, 1'b1);
            end else if (which < 9) begin
                set_key(2, 1'b0);
                repeat ($urandom_range(1, 40)) tick();
                set_key(2, 1'b1);
            end else begin
                key_start_n = 1'b0;
                key_reset_n = 1'b0;
                repeat ($urandom_range(15, 30)) tick();
                key_start_n = 1'b1;
                key_reset_n = 1'b1;
            end
            repeat ($urandom_range(1, 30)) tick();
        end
        at_max = 1'b0;
        repeat (N + 10) tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) check("scoreboard_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
